// File: rtl/acc_bank.sv
// Bank of MODN saturating accumulators with a frame-based snapshot/handshake output.
// Sums accumulate while running, hold in hold/end-of-frame, and are copied to the
// output registers once on each entry to end-of-frame.
module acc_bank #(
    parameter int unsigned MODN   = 30,
    parameter int unsigned DW     = 4,
    parameter int unsigned ADDW   = 14,
    parameter int unsigned SIGNED = 0,
    parameter int unsigned CNTW   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           state,
    input  logic                 in_valid,
    input  logic [MODN*DW-1:0]   diff_bus,
    output logic [MODN*ADDW-1:0] cnt_bus,
    output logic [MODN-1:0]      sat_bus,
    output logic [CNTW-1:0]      smp_cnt,
    output logic                 cnt_valid,
    input  logic                 cnt_ready,
    output logic                 overrun
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StHold = 2'b10,
        StEnd  = 2'b11
    } frame_state_e;

    frame_state_e state_q;

    logic [MODN-1:0][ADDW-1:0] sum_q, sum_d;
    logic [MODN-1:0]           sat_q, sat_d;
    logic [CNTW-1:0]           cnt_q, cnt_d;

    logic [MODN-1:0][ADDW-1:0] snap_sum_q, snap_sum_d;
    logic [MODN-1:0]           snap_sat_q, snap_sat_d;
    logic [CNTW-1:0]           snap_cnt_q, snap_cnt_d;
    logic                      valid_q, valid_d;
    logic                      overrun_q, overrun_d;

    logic [MODN-1:0][ADDW:0]   add_res;
    logic                      clr, acc_en, snap;

    // Returns {overflow, clamped sum}; the add is done one bit wider so range
    // violations are detected instead of wrapping.
    function automatic logic [ADDW:0] sat_add(input logic [ADDW-1:0] acc,
                                              input logic [DW-1:0]   smp);
        logic [ADDW:0]   a;
        logic [ADDW:0]   b;
        logic [ADDW:0]   s;
        logic            ovf;
        logic [ADDW-1:0] res;
        if (SIGNED != 0) begin
            a   = {acc[ADDW-1], acc};
            b   = {{(ADDW+1-DW){smp[DW-1]}}, smp};
            s   = a + b;
            ovf = s[ADDW] ^ s[ADDW-1];
            if (!ovf) begin
                res = s[ADDW-1:0];
            end else if (s[ADDW]) begin
                res = {1'b1, {(ADDW-1){1'b0}}};
            end else begin
                res = {1'b0, {(ADDW-1){1'b1}}};
            end
        end else begin
            a   = {1'b0, acc};
            b   = {{(ADDW+1-DW){1'b0}}, smp};
            s   = a + b;
            ovf = s[ADDW];
            res = ovf ? {ADDW{1'b1}} : s[ADDW-1:0];
        end
        return {ovf, res};
    endfunction

    // Frame control decode; clear wins over accumulate.
    always_comb begin
        clr    = (state == StIdle) || ((state == StRun) && (state_q == StEnd));
        acc_en = (state == StRun) && in_valid;
        snap   = (state == StEnd) && (state_q != StEnd);
    end

    // Per-channel saturating adder.
    always_comb begin
        add_res = '0;
        for (int i = 0; i < MODN; i++) begin
            add_res[i] = sat_add(sum_q[i], diff_bus[i*DW +: DW]);
        end
    end

    // Next-state for running sums, sticky saturation flags and sample counter.
    always_comb begin
        sum_d = sum_q;
        sat_d = sat_q;
        cnt_d = cnt_q;
        if (clr) begin
            sum_d = '0;
            sat_d = '0;
            cnt_d = '0;
        end else if (acc_en) begin
            for (int i = 0; i < MODN; i++) begin
                sum_d[i] = add_res[i][ADDW-1:0];
                sat_d[i] = sat_q[i] | add_res[i][ADDW];
            end
            if (cnt_q != {CNTW{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Next-state for snapshot registers and the valid/overrun handshake.
    always_comb begin
        snap_sum_d = snap_sum_q;
        snap_sat_d = snap_sat_q;
        snap_cnt_d = snap_cnt_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        if (snap) begin
            snap_sum_d = sum_q;
            snap_sat_d = sat_q;
            snap_cnt_d = cnt_q;
            valid_d    = 1'b1;
        end else if (valid_q && cnt_ready) begin
            valid_d = 1'b0;
        end
        if (state == StIdle) begin
            overrun_d = 1'b0;
        end else if (snap && valid_q && !cnt_ready) begin
            overrun_d = 1'b1;
        end
    end

    // State register for accumulators and frame control.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sum_q   <= '0;
            sat_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= frame_state_e'(state);
            sum_q   <= sum_d;
            sat_q   <= sat_d;
            cnt_q   <= cnt_d;
        end
    end

    // State register for the snapshot output side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            snap_sum_q <= '0;
            snap_sat_q <= '0;
            snap_cnt_q <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            snap_sum_q <= snap_sum_d;
            snap_sat_q <= snap_sat_d;
            snap_cnt_q <= snap_cnt_d;
            valid_q    <= valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign cnt_bus   = snap_sum_q;
    assign sat_bus   = snap_sat_q;
    assign smp_cnt   = snap_cnt_q;
    assign cnt_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: doc/acc_bank.md
ACC_BANK -- requirements
Module: acc_bank

Interface
REQ-001 The block SHALL have parameter MODN, default 30, number of accumulator channels.
REQ-002 The block SHALL have parameter DW, default 4, per-channel input sample width.
REQ-003 The block SHALL have parameter ADDW, default 14, per-channel accumulator width, with ADDW > DW.
REQ-004 The block SHALL have parameter SIGNED, default 0: 0 = unsigned samples, 1 = two's-complement samples.
REQ-005 The block SHALL have parameter CNTW, default 16, width of the frame sample counter.
REQ-006 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-008 The block SHALL have port state, input, 2 bits, frame control: 00 idle, 01 run, 10 hold, 11 end-of-frame.
REQ-009 The block SHALL have port in_valid, input, 1 bit, diff_bus carries a valid sample set this cycle.
REQ-010 The block SHALL have port diff_bus, input, MODN*DW bits, channel i at bits [i*DW +: DW].
REQ-011 The block SHALL have port cnt_bus, output, MODN*ADDW bits, snapshot sums, channel i at [i*ADDW +: ADDW].
REQ-012 The block SHALL have port sat_bus, output, MODN bits, per-channel snapshot saturation flags.
REQ-013 The block SHALL have port smp_cnt, output, CNTW bits, number of accepted samples in the snapshot frame.
REQ-014 The block SHALL have port cnt_valid, output, 1 bit, snapshot available.
REQ-015 The block SHALL have port cnt_ready, input, 1 bit, consumer accepts the snapshot.
REQ-016 The block SHALL have port overrun, output, 1 bit, sticky: a snapshot was overwritten unconsumed.

Function
REQ-017 The block SHALL register state into state_q each cycle; accumulate-enable = (state==01) && in_valid.
REQ-018 On accumulate-enable, each channel SHALL add its sample, zero-extended (SIGNED=0) or sign-extended (SIGNED=1) to ADDW, to its running sum.
REQ-019 Unsigned sums SHALL saturate at 2^ADDW-1; signed sums SHALL saturate at 2^(ADDW-1)-1 and -2^(ADDW-1); no wrap-around ever.
REQ-020 A channel whose add saturates (or would exceed range) SHALL set its sticky sat flag for the current frame.
REQ-021 The sample counter SHALL increment by 1 on accumulate-enable and saturate at 2^CNTW-1.
REQ-022 In state 10 and in state 11, sums, sat flags and sample counter SHALL hold.
REQ-023 Sums, sat flags and sample counter SHALL clear to 0 when state==00, or when state==01 and state_q==11 (new frame); clear has priority over accumulate.
REQ-024 On entry to end-of-frame (state==11, state_q!=11), the block SHALL copy the sums, sat flags and sample counter into cnt_bus, sat_bus and smp_cnt, and set cnt_valid, all visible the following cycle.
REQ-025 cnt_valid SHALL clear on a cycle with cnt_valid && cnt_ready && no new snapshot; cnt_bus, sat_bus and smp_cnt SHALL stay stable while cnt_valid is high, except when a new snapshot is taken.
REQ-026 Snapshot while cnt_valid=1 and cnt_ready=0 SHALL overwrite the outputs and set overrun; with cnt_ready=1 in the same cycle, overrun SHALL NOT be set and cnt_valid SHALL remain 1.
REQ-027 overrun SHALL clear only on reset or when state==00.
REQ-028 Remaining in state 11 for several cycles SHALL produce exactly one snapshot.

Reset
REQ-029 While rst_n=0, all sums, sat flags, sample counter, state_q, cnt_bus, sat_bus, smp_cnt, cnt_valid and overrun SHALL be 0, asynchronously.
REQ-030 Reset asserted mid-frame SHALL discard the frame; after release, the block SHALL behave as if in idle until state enters 01.

Verification
REQ-031 Defaults; run 10 cycles, in_valid=1, all channels 4'hF; then state 11 -> cnt_valid=1, every channel 150, smp_cnt=10, sat_bus=0.
REQ-032 Defaults; run 1100 cycles of 4'hF -> channel sums 16383, sat_bus all 1, smp_cnt=1100.
REQ-033 SIGNED=1; channel 0 gets 4'h8 (-8) for 3000 cycles -> cnt_bus[0] = -8192 (14'h2000), sat_bus[0]=1.
REQ-034 With in_valid toggling 1/0 over 8 run cycles of value 2, interleaved with hold cycles -> sums 8, smp_cnt=4.
REQ-035 With cnt_ready=0, two frames ending 11->01->11 -> second snapshot visible, overrun=1; with cnt_ready=1 on the second snapshot cycle -> overrun=0 and cnt_valid=1.
REQ-036 rst_n pulsed low mid-run -> all outputs 0 immediately; next frame sums start from 0.
